ctrl_update_queue: RTL and testbench



---
 rtl/ctrl_update_queue_if.sv | 34 +++
 rtl/ctrl_update_queue.sv | 117 +++++++++++
 tb/tb_ctrl_update_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_update_queue_if.sv
// Commit-side bus into the BTB update queue: two retiring control slots
// plus the back-pressure returned to commit.
interface ctrl_update_queue_if #(
  parameter int SIZE_PC     = 32,
  parameter int BRANCH_TYPE = 2
);
  logic                   commitValid0_i;
  logic [SIZE_PC-1:0]     commitPC0_i;
  logic [SIZE_PC-1:0]     commitTarget0_i;
  logic [BRANCH_TYPE-1:0] commitBrType0_i;
  logic                   commitNeedUpd0_i;
  logic                   commitValid1_i;
  logic [SIZE_PC-1:0]     commitPC1_i;
  logic [SIZE_PC-1:0]     commitTarget1_i;
  logic [BRANCH_TYPE-1:0] commitBrType1_i;
  logic                   commitNeedUpd1_i;
  logic                   stallCommit_o;

  modport master (
    output commitValid0_i, commitPC0_i, commitTarget0_i,
    output commitBrType0_i, commitNeedUpd0_i,
    output commitValid1_i, commitPC1_i, commitTarget1_i,
    output commitBrType1_i, commitNeedUpd1_i,
    input  stallCommit_o
  );

  modport slave (
    input  commitValid0_i, commitPC0_i, commitTarget0_i,
    input  commitBrType0_i, commitNeedUpd0_i,
    input  commitValid1_i, commitPC1_i, commitTarget1_i,
    input  commitBrType1_i, commitNeedUpd1_i,
    output stallCommit_o
  );
endinterface

// File: rtl/ctrl_update_queue.sv
// Commit-side BTB update writer: filters two retiring slots per cycle,
// queues them in program order and drains one registered pulse per cycle.
module ctrl_update_queue #(
  parameter int SIZE_PC     = 32,
  parameter int BRANCH_TYPE = 2,
  parameter int DEPTH       = 16,
  parameter int DEPTH_LOG   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  ctrl_update_queue_if.slave     cq,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   updateEn_o,
  output logic [SIZE_PC-1:0]     updatePC_o,
  output logic [SIZE_PC-1:0]     updateTargetAddr_o,
  output logic [BRANCH_TYPE-1:0] updateBrType_o,
  output logic [DEPTH_LOG:0]     count_o,
  output logic                   overflow_o
);
  localparam int PW = DEPTH_LOG;
  localparam int CW = DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [SIZE_PC-1:0]     pc;
    logic [SIZE_PC-1:0]     tgt;
    logic [BRANCH_TYPE-1:0] ty;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  entry_t        upd_q, upd_d;
  logic          ovf_q, ovf_d;

  logic          q0, q1, fits, enq, deq;
  logic [1:0]    need;
  logic [CW-1:0] free;
  entry_t        e0, e1;

  assign free = DEPTH_C - count_q;
  assign cq.stallCommit_o = free < CW'(2);

  always_comb begin
    q0   = cq.commitValid0_i & cq.commitNeedUpd0_i;
    q1   = cq.commitValid1_i & cq.commitNeedUpd1_i;
    need = {1'b0, q0} + {1'b0, q1};
    fits = CW'(need) <= free;
    enq  = !flush_i && fits && (q0 || q1);
    deq  = !flush_i && !stall_i && (count_q != '0);
    e0   = '{pc: cq.commitPC0_i, tgt: cq.commitTarget0_i,
             ty: cq.commitBrType0_i};
    e1   = '{pc: cq.commitPC1_i, tgt: cq.commitTarget1_i,
             ty: cq.commitBrType1_i};

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    en_d    = 1'b0;
    upd_d   = upd_q;
    // a rejected cycle drops both slots; flush ignores inputs entirely
    ovf_d   = ovf_q | (!flush_i && !fits);

    if (enq) begin
      if (q0) mem_d[tail_q] = e0;
      if (q1) mem_d[tail_q + PW'(q0)] = e1;
      tail_d = tail_q + PW'(need);
    end
    if (deq) begin
      en_d   = 1'b1;
      upd_d  = mem_q[head_q];
      head_d = head_q + PW'(1);
    end
    count_d = count_q + (enq ? CW'(need) : '0) - (deq ? CW'(1) : '0);

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      en_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      upd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      en_q    <= en_d;
      upd_q   <= upd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign updateEn_o         = en_q;
  assign updatePC_o         = upd_q.pc;
  assign updateTargetAddr_o = upd_q.tgt;
  assign updateBrType_o     = upd_q.ty;
  assign count_o            = count_q;
  assign overflow_o         = ovf_q;
endmodule

// File: tb/tb_ctrl_update_queue.sv
// Directed bench for ctrl_update_queue: single, filter, fill/drain with
// wrap, overflow, flush and reset mid-drain.
module tb_ctrl_update_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i;
  logic        upd_en;
  logic [31:0] upd_pc, upd_tgt;
  logic [1:0]  upd_ty;
  logic [4:0]  cnt;
  logic        ovf;
  int          checks = 0;
  int          errors = 0;

  ctrl_update_queue_if #(.SIZE_PC(32), .BRANCH_TYPE(2)) cq ();

  ctrl_update_queue #(
    .SIZE_PC(32), .BRANCH_TYPE(2), .DEPTH(16), .DEPTH_LOG(4)
  ) dut (
    .clk(clk), .reset(reset), .cq(cq.slave),
    .stall_i(stall_i), .flush_i(flush_i),
    .updateEn_o(upd_en), .updatePC_o(upd_pc),
    .updateTargetAddr_o(upd_tgt), .updateBrType_o(upd_ty),
    .count_o(cnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cq.commitValid0_i = 0; cq.commitNeedUpd0_i = 0;
    cq.commitPC0_i = 0; cq.commitTarget0_i = 0; cq.commitBrType0_i = 0;
    cq.commitValid1_i = 0; cq.commitNeedUpd1_i = 0;
    cq.commitPC1_i = 0; cq.commitTarget1_i = 0; cq.commitBrType1_i = 0;
  endtask

  task automatic set0(bit v, bit n, logic [31:0] pc,
                      logic [31:0] tgt, logic [1:0] ty);
    cq.commitValid0_i = v; cq.commitNeedUpd0_i = n;
    cq.commitPC0_i = pc; cq.commitTarget0_i = tgt;
    cq.commitBrType0_i = ty;
  endtask

  task automatic set1(bit v, bit n, logic [31:0] pc,
                      logic [31:0] tgt, logic [1:0] ty);
    cq.commitValid1_i = v; cq.commitNeedUpd1_i = n;
    cq.commitPC1_i = pc; cq.commitTarget1_i = tgt;
    cq.commitBrType1_i = ty;
  endtask

  // target = pc + 0x100 for all bulk entries
  task automatic dual(logic [31:0] pc0, logic [1:0] ty0,
                      logic [31:0] pc1, logic [1:0] ty1);
    set0(1, 1, pc0, pc0 + 32'h100, ty0);
    set1(1, 1, pc1, pc1 + 32'h100, ty1);
  endtask

  initial begin
    logic [31:0] pc;
    reset = 0; stall_i = 0; flush_i = 0;
    idle();
    step(); step();
    chk("rst_en", upd_en, 0);
    chk("rst_pc", upd_pc, 0);
    chk("rst_tgt", upd_tgt, 0);
    chk("rst_ty", upd_ty, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stall", cq.stallCommit_o, 0);
    reset = 1;
    step();

    // single update, two-cycle latency
    set0(1, 1, 32'h1000, 32'h2000, 2'd2);
    step(); idle();
    chk("s1_cnt1", cnt, 1);
    chk("s1_en0", upd_en, 0);
    step();
    chk("s1_en", upd_en, 1);
    chk("s1_pc", upd_pc, 32'h1000);
    chk("s1_tgt", upd_tgt, 32'h2000);
    chk("s1_ty", upd_ty, 2);
    chk("s1_cnt0", cnt, 0);
    step();
    chk("s1_pulse", upd_en, 0);
    chk("s1_hold", upd_pc, 32'h1000);

    // filter and compaction
    set0(1, 0, 32'h1004, 32'h3004, 2'd3);
    set1(1, 1, 32'h1008, 32'h3008, 2'd1);
    step(); idle();
    chk("f_cnt", cnt, 1);
    step();
    chk("f_en", upd_en, 1);
    chk("f_pc", upd_pc, 32'h1008);
    chk("f_tgt", upd_tgt, 32'h3008);
    chk("f_ty", upd_ty, 1);
    step();
    chk("f_en0", upd_en, 0);
    chk("f_cnt0", cnt, 0);

    // dual fill under stall, then drain in order (pointers wrap)
    stall_i = 1;
    for (int i = 0; i < 8; i++) begin
      dual(32'h4000 + 32'(16 * i), 2'(2 * i),
           32'h4008 + 32'(16 * i), 2'(2 * i + 1));
      step();
      chk("fill_cnt", cnt, 64'(2 * (i + 1)));
      chk("fill_stall", cq.stallCommit_o, (i == 7) ? 1 : 0);
    end
    idle();
    chk("fill_en", upd_en, 0);
    stall_i = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      pc = 32'h4000 + 32'(8 * j);
      chk("dr_en", upd_en, 1);
      chk("dr_pc", upd_pc, pc);
      chk("dr_tgt", upd_tgt, pc + 32'h100);
      chk("dr_ty", upd_ty, 64'(j % 4));
    end
    chk("dr_cnt", cnt, 0);
    step();
    chk("dr_en0", upd_en, 0);

    // overflow at count 15
    stall_i = 1;
    for (int i = 0; i < 7; i++) begin
      dual(32'h5000 + 32'(16 * i), 0, 32'h5008 + 32'(16 * i), 0);
      step();
    end
    idle();
    set0(1, 1, 32'h5070, 32'h5170, 0);
    step();
    chk("ov_cnt15", cnt, 15);
    chk("ov_stall", cq.stallCommit_o, 1);
    chk("ov_pre", ovf, 0);
    dual(32'h6000, 1, 32'h6008, 1);
    step(); idle();
    chk("ov_cnt", cnt, 15);
    chk("ov_set", ovf, 1);
    stall_i = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      chk("ov_en", upd_en, 1);
      chk("ov_pc", upd_pc, 32'h5000 + 32'(8 * j));
    end
    step();
    chk("ov_en0", upd_en, 0);
    chk("ov_cnt0", cnt, 0);
    chk("ov_sticky", ovf, 1);

    // flush mid-drain
    stall_i = 1;
    dual(32'h7000, 0, 32'h7008, 0); step();
    dual(32'h7010, 0, 32'h7018, 0); step();
    idle();
    set0(1, 1, 32'h7020, 32'h7120, 0); step();
    idle();
    chk("fl_cnt5", cnt, 5);
    stall_i = 0;
    step();
    chk("fl_en", upd_en, 1);
    chk("fl_pc", upd_pc, 32'h7000);
    chk("fl_cnt4", cnt, 4);
    flush_i = 1;
    set0(1, 1, 32'h7100, 32'h7200, 0);
    step();
    flush_i = 0; idle();
    chk("fl_cnt", cnt, 0);
    chk("fl_en0", upd_en, 0);
    chk("fl_ovf", ovf, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("fl_quiet", upd_en, 0);
      chk("fl_qcnt", cnt, 0);
    end

    // reset mid-drain, then a fresh single update
    stall_i = 1;
    dual(32'hA000, 1, 32'hA008, 1); step();
    idle(); stall_i = 0;
    step();
    chk("rd_en", upd_en, 1);
    chk("rd_pc", upd_pc, 32'hA000);
    reset = 0;
    step();
    chk("rd_en0", upd_en, 0);
    chk("rd_pc0", upd_pc, 0);
    chk("rd_tgt0", upd_tgt, 0);
    chk("rd_ty0", upd_ty, 0);
    chk("rd_cnt0", cnt, 0);
    chk("rd_ovf0", ovf, 0);
    chk("rd_stall0", cq.stallCommit_o, 0);
    reset = 1;
    step();
    chk("rd_quiet", upd_en, 0);
    set0(1, 1, 32'h1000, 32'h2000, 2'd2);
    step(); idle();
    chk("rd_cnt1", cnt, 1);
    step();
    chk("rd_s_en", upd_en, 1);
    chk("rd_s_pc", upd_pc, 32'h1000);
    chk("rd_s_tgt", upd_tgt, 32'h2000);
    chk("rd_s_ty", upd_ty, 2);
    step();
    chk("rd_s_en0", upd_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
